// File: rtl/result_collector.sv
// result_collector
//   Collects one frame of result words from the kernel pipeline into an
//   internal frame buffer and offers a registered read port on that buffer.
//
//   Parameters
//     DATA_W        width of each result word
//     ADDR_W        frame buffer address width
//     FRAME_PIXELS  results per frame
//
//   Ports
//     clk            single clock, rising edge
//     n_rst          asynchronous active-low reset
//     start          one-cycle pulse, arms collection of a new frame
//     result         result-valid strobe
//     output_result  result word, valid with result
//     rd_en/rd_addr  buffer read request / address
//     rd_data        read data, one cycle after rd_en; held while rd_en=0
//     rd_valid       rd_data valid
//     busy           collecting a frame
//     frame_done     full frame stored
//     overflow       sticky: a result arrived while not collecting
//     wr_count       results stored in the current frame
//
//   Build option
//     RESULT_SATURATE_EN  clamp stored words: negative -> 0, above 255 -> 255
module result_collector #(
  parameter int DATA_W       = 13,
  parameter int ADDR_W       = 12,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              result,
  input  logic [DATA_W-1:0] output_result,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W+1)'(FRAME_PIXELS);

  state_t            state;
  state_t            state_nx;
  logic              wr_en;
  logic              cnt_clr;
  logic              ovf_set;
  logic              last_wr;
  logic              rd_in_range;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] mem [FRAME_PIXELS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // start wins over a coincident result: the result is neither stored
  // nor counted as an overflow.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    ovf_set  = 1'b0;
    last_wr  = (wr_count == (FRAME_LEN - 1'b1));
    if (start) begin
      state_nx = COLLECT;
      cnt_clr  = 1'b1;
    end else if (result) begin
      case (state)
        COLLECT: begin
          wr_en = 1'b1;
          if (last_wr) begin
            state_nx = DONE;
          end
        end
        default: ovf_set = 1'b1;
      endcase
    end
  end

  assign busy       = (state == COLLECT);
  assign frame_done = (state == DONE);

  // ------------------------------------------------------ count / flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_count <= '0;
    end else if (cnt_clr) begin
      wr_count <= '0;
    end else if (wr_en) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow <= 1'b0;
    end else if (cnt_clr) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end
  end

  // ------------------------------------------------------ write data path
`ifdef RESULT_SATURATE_EN
  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(255);

  always_comb begin
    wr_word = output_result;
    if (output_result[DATA_W-1]) begin
      wr_word = '0;
    end else if (output_result > SAT_MAX) begin
      wr_word = SAT_MAX;
    end
  end
`else
  always_comb begin
    wr_word = output_result;
  end
`endif

  // ------------------------------------------------------ frame buffer
  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_count[ADDR_W-1:0]] <= wr_word;
    end
  end

  assign rd_in_range = ({1'b0, rd_addr} < FRAME_LEN);

  // Same-edge read of the address being written returns the old word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with an abstract frame model and a
// per-cycle compare process.
module tb_result_collector;

  localparam int DW = 13;
  localparam int AW = 12;
  localparam int FP = 4096;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic          result = 1'b0;
  logic [DW-1:0] output_result = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [AW:0]   wr_count;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  result_collector #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .result       (result),
    .output_result(output_result),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit            m_coll = 1'b0;
  bit            m_done = 1'b0;
  bit            m_ovf = 1'b0;
  int            m_cnt = 0;
  bit            m_rdv = 1'b0;
  bit            m_rdk = 1'b1;
  logic [DW-1:0] m_rdd = '0;
  logic [DW-1:0] m_mem [FP];
  bit            m_known [FP];

  function automatic logic [DW-1:0] store_val(input logic [DW-1:0] d);
`ifdef RESULT_SATURATE_EN
    if (d[DW-1]) return '0;
    if (d > 13'd255) return 13'd255;
`endif
    return d;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_coll = 1'b0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_rdv  = 1'b0;
      m_rdd  = '0;
      m_rdk  = 1'b1;
    end else begin
      // read sees the buffer as it was before this edge's write
      m_rdv = rd_en;
      if (rd_en) begin
        if (int'(rd_addr) >= FP) begin
          m_rdd = '0;
          m_rdk = 1'b1;
        end else begin
          m_rdd = m_mem[rd_addr];
          m_rdk = m_known[rd_addr];
        end
      end
      if (start) begin
        m_coll = 1'b1;
        m_done = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
      end else if (result) begin
        if (m_coll) begin
          m_mem[m_cnt]   = store_val(output_result);
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          if (m_cnt == FP) begin
            m_coll = 1'b0;
            m_done = 1'b1;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("busy",       32'(busy),       32'(m_coll));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("wr_count",   32'(wr_count),   32'(m_cnt));
      chk("rd_valid",   32'(rd_valid),   32'(m_rdv));
      if (m_rdk) chk("rd_data", 32'(rd_data), 32'(m_rdd));
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Tasks start at a falling edge and return at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    result        = 1'b1;
    output_result = d;
    @(negedge clk);
    result = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  logic [DW-1:0] d;
  logic          v;

  initial begin
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(frame_done), 32'd0);
    chk("rst_ovf",      32'(overflow), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    run_cmp = 1'b1;
    n_rst   = 1'b1;
    @(negedge clk);

    // full frame on consecutive cycles
    pulse_start();
    chk("armed_busy", 32'(busy), 32'd1);
    for (int i = 0; i < FP; i++) send(DW'(i % 8192));
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("frame_count", 32'(wr_count), 32'd4096);
    chk("frame_busy", 32'(busy), 32'd0);
    rd(12'd100, d, v);
    chk("rd100_valid", 32'(v), 32'd1);
    chk("rd100_data", 32'(d), 32'd100);
    @(negedge clk);
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_data", 32'(rd_data), 32'd100);

    // result while DONE
    send(13'h1ABC);
    chk("done_ovf", 32'(overflow), 32'd1);
    chk("done_count", 32'(wr_count), 32'd4096);
    rd(12'd0, d, v);
    chk("done_buf0", 32'(d), 32'd0);
    pulse_start();
    chk("start_clr_ovf", 32'(overflow), 32'd0);
    chk("start_clr_cnt", 32'(wr_count), 32'd0);

    // sparse results, 20 cycles apart
    for (int k = 0; k < 5; k++) begin
      send(DW'(10 + k));
      chk("sparse_count", 32'(wr_count), 32'(k + 1));
      chk("sparse_busy", 32'(busy), 32'd1);
      repeat (19) @(negedge clk);
      chk("sparse_hold", 32'(wr_count), 32'(k + 1));
    end

    // start and result together
    start = 1'b1;
    result = 1'b1;
    output_result = 13'h0055;
    @(negedge clk);
    start = 1'b0;
    result = 1'b0;
    chk("coinc_count", 32'(wr_count), 32'd0);
    chk("coinc_ovf", 32'(overflow), 32'd0);
    rd(12'd5, d, v);
    chk("coinc_nowrite", 32'(d), 32'd5);

    // read and write the same address in one cycle
    result = 1'b1;
    output_result = 13'h0077;
    rd_en = 1'b1;
    rd_addr = 12'd0;
    @(negedge clk);
    result = 1'b0;
    rd_en = 1'b0;
    chk("rw_old", 32'(rd_data), 32'd10);
    rd(12'd0, d, v);
    chk("rw_new", 32'(d), 32'h77);

    // reset mid-frame after 10 writes
    for (int k = 1; k < 10; k++) send(DW'(k));
    chk("pre_rst_count", 32'(wr_count), 32'd10);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_count", 32'(wr_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    send(13'd3);
    chk("post_rst_ovf", 32'(overflow), 32'd1);
    chk("post_rst_count", 32'(wr_count), 32'd0);

    // storage transform
    pulse_start();
    send(13'h1FFF);
    send(13'h0300);
    rd(12'd0, d, v);
`ifdef RESULT_SATURATE_EN
    chk("sat_neg", 32'(d), 32'd0);
`else
    chk("raw_1fff", 32'(d), 32'h1FFF);
`endif
    rd(12'd1, d, v);
`ifdef RESULT_SATURATE_EN
    chk("sat_big", 32'(d), 32'd255);
`else
    chk("raw_0300", 32'(d), 32'h0300);
`endif

    repeat (3) @(negedge clk);
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The module SHALL have parameter DATA_W, default 13: width of each result word.
REQ-002 The module SHALL have parameter ADDR_W, default 12: frame buffer address width.
REQ-003 The module SHALL have parameter FRAME_PIXELS, default 4096: results per frame (64x64).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: one-cycle pulse that arms collection of a new frame.
REQ-007 The module SHALL have port result, input, 1 bit: result-valid strobe from the kernel pipeline.
REQ-008 The module SHALL have port output_result, input, DATA_W bits: result word, valid when result=1.
REQ-009 The module SHALL have port rd_en, input, 1 bit: frame buffer read request.
REQ-010 The module SHALL have port rd_addr, input, ADDR_W bits: frame buffer read address.
REQ-011 The module SHALL have port rd_data, output, DATA_W bits: read data.
REQ-012 The module SHALL have port rd_valid, output, 1 bit: rd_data valid.
REQ-013 The module SHALL have port busy, output, 1 bit: high while in COLLECT.
REQ-014 The module SHALL have port frame_done, output, 1 bit: high in DONE.
REQ-015 The module SHALL have port overflow, output, 1 bit: sticky flag for a result received outside COLLECT.
REQ-016 The module SHALL have port wr_count, output, ADDR_W+1 bits: number of results stored in the current frame.

Function
REQ-017 The module SHALL implement a FSM with states IDLE, COLLECT and DONE; it SHALL enter IDLE from reset.
REQ-018 On start=1 in any state, the FSM SHALL go to COLLECT next cycle, and wr_count SHALL clear to 0 on that edge.
REQ-019 In COLLECT, a cycle with result=1 SHALL write output_result (after the REQ-031 transform) to buffer[wr_count] and increment wr_count at the same edge.
REQ-020 The write that makes wr_count equal FRAME_PIXELS SHALL move the FSM to DONE on the same edge, so frame_done is high from the next cycle.
REQ-021 In DONE, the FSM SHALL stay until start=1.
REQ-022 A result=1 in IDLE or DONE SHALL NOT write to the buffer and SHALL set overflow; overflow SHALL clear only on start or reset.
REQ-023 If start=1 and result=1 occur in the same cycle, start SHALL take priority: the result is dropped, overflow is not set, and wr_count becomes 0.
REQ-024 The frame buffer SHALL be FRAME_PIXELS x DATA_W, with one write port and one read port.
REQ-025 Reads SHALL have 1-cycle latency: rd_en=1 at edge N gives rd_data=buffer[rd_addr] and rd_valid=1 after edge N+1.
REQ-026 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-027 Reads SHALL be allowed in every state.
REQ-028 A read and a write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-029 rd_addr values at or above FRAME_PIXELS SHALL return 0 with rd_valid=1.

Reset
REQ-030 While n_rst=0, the module SHALL force state=IDLE, wr_count=0, busy=0, frame_done=0, overflow=0, rd_valid=0 and rd_data=0; buffer contents are not reset. Reset asserted mid-frame SHALL abandon the frame, and a new start SHALL be required.

Configuration
REQ-031 With macro RESULT_SATURATE_EN defined, each stored word SHALL be clamped before the write: a word with MSB=1 (negative, two's complement) is stored as 0; a word greater than 255 is stored as 255; any other word is stored unchanged. Without the macro, output_result SHALL be stored unmodified.

Verification
REQ-032 The bench SHALL reset, pulse start, then send 4096 results with output_result = index mod 8192 on consecutive cycles -> frame_done=1 one cycle after the last write, wr_count=4096, and a readback of address 100 gives 100.
REQ-033 The bench SHALL send results spaced 20 cycles apart, as the kernel pipeline delivers them -> wr_count increments only on strobe cycles, and busy=1 throughout.
REQ-034 The bench SHALL send result=1 while in DONE -> overflow=1, and buffer[0] is unchanged; a following start clears overflow.
REQ-035 The bench SHALL assert start and result in the same cycle -> wr_count=0, overflow=0, and no write occurs.
REQ-036 The bench SHALL assert n_rst=0 after 10 writes -> IDLE and wr_count=0 immediately; results sent after release set overflow.
REQ-037 With RESULT_SATURATE_EN defined, the bench SHALL write 0x1FFF and 0x0300 -> readback gives 0 and 255; without the macro, readback gives 0x1FFF and 0x0300.
